// File: rtl/jk_excitation_driver.sv
// Write-side driver for an external JK flip-flop bank: buffers target words in a
// small FIFO, drives one cycle of J/K excitation per word, then checks the bank's state.
module jk_excitation_driver #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int ERRW  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             tog_mode,
  input  logic [WIDTH-1:0] q_fb,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic             jk_valid,
  output logic             chk_done,
  output logic             mismatch,
  output logic [ERRW-1:0]  err_count,
  input  logic             clr_err,
  output logic             busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     PTR_ONE = 1;
  localparam logic [ERRW-1:0] ERR_ONE = 1;

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] head;
  logic             empty, full, push, pop, fail;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = d_valid && !full;
  assign pop   = !empty && ((state == IDLE) || (state == CHECK));
  assign head  = mem[rd_ptr[AW-1:0]];
  assign fail  = (state == CHECK) && (q_fb != target);

  assign d_ready = !full;
  assign busy    = (state != IDLE) || !empty;

  // NOTE: the storage array has no reset; contents are only read behind a valid
  // pointer pair, so clearing it would just cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= d_in;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      j         <= '0;
      k         <= '0;
      jk_valid  <= 1'b0;
      chk_done  <= 1'b0;
      target    <= '0;
      mismatch  <= 1'b0;
      err_count <= '0;
    end else begin
      chk_done <= (state == CHECK);

      // Both policies land q_next on the target: set/reset forces every bit,
      // toggle flips only the bits that differ from the current bank state.
      if (pop) begin
        target   <= head;
        j        <= tog_mode ? (head ^ q_fb) : head;
        k        <= tog_mode ? (head ^ q_fb) : ~head;
        jk_valid <= 1'b1;
        state    <= DRIVE;
      end else begin
        j        <= '0;
        k        <= '0;
        jk_valid <= 1'b0;
        case (state)
          DRIVE:   state <= CHECK;
          CHECK:   state <= IDLE;
          default: state <= IDLE;
        endcase
      end

      // A failing check outranks a simultaneous clear, leaving a count of one.
      if (fail) begin
        mismatch <= 1'b1;
        if (clr_err)                err_count <= ERR_ONE;
        else if (err_count != '1)   err_count <= err_count + ERR_ONE;
      end else if (clr_err) begin
        mismatch  <= 1'b0;
        err_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Self-checking bench for jk_excitation_driver: directed vector table, burst,
// fault-injection and reset sequences, plus randomized traffic against a word-level model.
module tb_jk_excitation_driver;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int ERRW  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] d_in = '0;
  logic             d_valid = 1'b0;
  logic             d_ready;
  logic             tog_mode = 1'b0;
  logic [WIDTH-1:0] q_fb;
  logic [WIDTH-1:0] j, k;
  logic             jk_valid, chk_done, mismatch, busy;
  logic [ERRW-1:0]  err_count;
  logic             clr_err = 1'b0;

  jk_excitation_driver #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ERRW(ERRW)) dut (
    .clk(clk), .rst(rst), .d_in(d_in), .d_valid(d_valid), .d_ready(d_ready),
    .tog_mode(tog_mode), .q_fb(q_fb), .j(j), .k(k), .jk_valid(jk_valid),
    .chk_done(chk_done), .mismatch(mismatch), .err_count(err_count),
    .clr_err(clr_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // External JK bank: q_next = (j & ~q) | (~k & q), with optional stuck-at-0 bits on feedback.
  logic [WIDTH-1:0] q_bank;
  logic             bank_load = 1'b1;
  logic [WIDTH-1:0] bank_val = '0;
  logic [WIDTH-1:0] stuck = '0;
  always @(posedge clk) begin
    if (bank_load) q_bank <= bank_val;
    else           q_bank <= (j & ~q_bank) | (~k & q_bank);
  end
  assign q_fb = q_bank & ~stuck;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Word-level scoreboard: each accepted word with the policy in force when it was pushed.
  typedef struct { logic [WIDTH-1:0] t; logic mode; } sb_t;
  sb_t              sb_q[$];
  logic             sb_on = 1'b0;
  logic [WIDTH-1:0] model_q = '0;
  int               cyc = 0;
  int               chk_cnt = 0;
  int               jk_stamps[$];

  always @(negedge clk) begin
    sb_t              e;
    logic [WIDTH-1:0] ej, ek;
    cyc++;
    if (jk_valid) begin
      jk_stamps.push_back(cyc);
      if (sb_on) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_jk", 32'(sb_q.size()), 1);
        end else begin
          e = sb_q.pop_front();
          ej = e.mode ? (e.t ^ model_q) : e.t;
          ek = e.mode ? (e.t ^ model_q) : ~e.t;
          check("sb_j", j, ej);
          check("sb_k", k, ek);
          model_q = e.t;
        end
      end
    end
    if (chk_done) begin
      chk_cnt++;
      if (sb_on) check("sb_mismatch", mismatch, 0);
    end
  end

  int pushes = 0;
  int blocked_at = -1;

  task automatic push_word(input logic [WIDTH-1:0] w);
    int guard = 0;
    d_valid = 1'b1;
    d_in    = w;
    while (!d_ready && guard < 50) begin
      if (blocked_at < 0) blocked_at = pushes;
      @(negedge clk); #1;
      guard++;
    end
    if (!d_ready) begin
      check("push_timeout", d_ready, 1);
    end else begin
      if (sb_on) sb_q.push_back('{t: w, mode: tog_mode});
      pushes++;
      @(negedge clk); #1;
    end
    d_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while (busy && guard < 2000) begin
      @(negedge clk); #1;
      guard++;
    end
    check({name, "_idle_timeout"}, busy, 0);
    @(negedge clk); #1;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); #1;
    end
  endtask

  typedef struct {
    logic             mode;
    logic [WIDTH-1:0] q0, t, ej, ek;
  } vec_t;
  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    vecs[0] = '{mode: 1'b0, q0: 4'b0000, t: 4'b1010, ej: 4'b1010, ek: 4'b0101};
    vecs[1] = '{mode: 1'b1, q0: 4'b1010, t: 4'b1001, ej: 4'b0011, ek: 4'b0011};
    vecs[2] = '{mode: 1'b0, q0: 4'b1111, t: 4'b0000, ej: 4'b0000, ek: 4'b1111};
    vecs[3] = '{mode: 1'b1, q0: 4'b0110, t: 4'b0110, ej: 4'b0000, ek: 4'b0000};
    vecs[4] = '{mode: 1'b1, q0: 4'b0000, t: 4'b1111, ej: 4'b1111, ek: 4'b1111};
    vecs[5] = '{mode: 1'b0, q0: 4'b0101, t: 4'b1111, ej: 4'b1111, ek: 4'b0000};

    // Reset, then ten idle cycles.
    tick(3);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      check("rst_j", j, 0);
      check("rst_k", k, 0);
      check("rst_jk_valid", jk_valid, 0);
      check("rst_d_ready", d_ready, 1);
      check("rst_mismatch", mismatch, 0);
      check("rst_err_count", err_count, 0);
      check("rst_busy", busy, 0);
    end
    bank_load = 1'b0;

    // Directed vectors with cycle-exact latency.
    for (int i = 0; i < 6; i++) begin
      bank_load = 1'b1;
      bank_val  = vecs[i].q0;
      tog_mode  = vecs[i].mode;
      @(negedge clk); #1;
      bank_load = 1'b0;
      c0 = chk_cnt;
      push_word(vecs[i].t);
      check($sformatf("v%0d_no_same_edge_pop", i), jk_valid, 0);
      @(negedge clk); #1;
      check($sformatf("v%0d_jk_valid", i), jk_valid, 1);
      check($sformatf("v%0d_j", i), j, vecs[i].ej);
      check($sformatf("v%0d_k", i), k, vecs[i].ek);
      @(negedge clk); #1;
      check($sformatf("v%0d_drive_one_cycle", i), jk_valid, 0);
      check($sformatf("v%0d_j_hold", i), {j, k}, 0);
      check($sformatf("v%0d_bank", i), q_fb, vecs[i].t);
      check($sformatf("v%0d_chk_early", i), chk_done, 0);
      @(negedge clk); #1;
      check($sformatf("v%0d_chk_done", i), chk_done, 1);
      check($sformatf("v%0d_mismatch", i), mismatch, 0);
      @(negedge clk); #1;
      check($sformatf("v%0d_chk_pulse", i), chk_done, 0);
      check($sformatf("v%0d_busy", i), busy, 0);
      check($sformatf("v%0d_chk_count", i), chk_cnt - c0, 1);
    end

    // Continuous burst of 8 words: FIFO fills, words drain at 2 cycles each.
    model_q = q_bank;
    tog_mode = 1'b0;
    sb_on = 1'b1;
    jk_stamps.delete();
    c0 = chk_cnt;
    pushes = 0;
    blocked_at = -1;
    for (int i = 0; i < 8; i++) push_word(4'(i * 3 + 1));
    wait_idle("burst");
    check("burst_ready_drop", blocked_at, 7);
    check("burst_jk_count", jk_stamps.size(), 8);
    for (int i = 1; i < jk_stamps.size(); i++)
      check($sformatf("burst_spacing_%0d", i), jk_stamps[i] - jk_stamps[i-1], 2);
    check("burst_chk_count", chk_cnt - c0, 8);
    check("burst_sb_empty", sb_q.size(), 0);

    // Randomized traffic; policy changes only while idle.
    c0 = chk_cnt;
    pushes = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy && $urandom_range(0, 3) == 0) tog_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0) push_word(4'($urandom_range(0, 15)));
      else tick($urandom_range(1, 3));
    end
    wait_idle("rand");
    check("rand_chk_count", chk_cnt - c0, pushes);
    check("rand_sb_empty", sb_q.size(), 0);
    check("rand_bank", q_fb, model_q);
    sb_on = 1'b0;

    // Fault injection: feedback bit0 stuck at 0.
    stuck = 4'b0001;
    tog_mode = 1'b0;
    push_word(4'b0001);
    wait_idle("fault1");
    check("fault_mismatch", mismatch, 1);
    check("fault_err_count", err_count, 1);
    clr_err = 1'b1;
    @(negedge clk); #1;
    clr_err = 1'b0;
    check("clr_mismatch", mismatch, 0);
    check("clr_err_count", err_count, 0);
    for (int i = 0; i < 300; i++) push_word(4'b0001);
    wait_idle("fault300");
    check("sat_err_count", err_count, 255);
    check("sat_mismatch", mismatch, 1);
    // Clear on the same edge as a failing check: failure wins.
    push_word(4'b0001);
    tick(2);
    clr_err = 1'b1;
    @(negedge clk); #1;
    clr_err = 1'b0;
    check("prio_err_count", err_count, 1);
    check("prio_mismatch", mismatch, 1);
    wait_idle("prio");
    stuck = '0;

    // Reset while driving with three words still queued.
    for (int i = 0; i < 6; i++) push_word(4'(i + 5));
    check("rst_mid_in_drive", jk_valid, 1);
    c0 = chk_cnt;
    rst = 1'b0;
    #1;
    check("rst_mid_j", j, 0);
    check("rst_mid_k", k, 0);
    check("rst_mid_jk_valid", jk_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_d_ready", d_ready, 1);
    check("rst_mid_err", {mismatch, err_count}, 0);
    tick(2);
    rst = 1'b1;
    tick(10);
    check("rst_mid_no_chk", chk_cnt - c0, 0);
    check("rst_mid_busy_after", busy, 0);
    check("rst_mid_ready_after", d_ready, 1);
    check("rst_mid_mismatch_after", mismatch, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
